weight_mem_ctrl: RTL and testbench
==================================

Name: weight_mem_ctrl

Overview:
Sequencer and arbiter for a bank of per-neuron weight memories in one layer. It accepts a load command and a stream of weight words, and writes them into the selected neuron's memory. Between loads it generates the read-address sequence that steps every neuron memory through its weights in lock-step with incoming input samples. Loading and inference reads are mutually exclusive; this block owns that arbitration.

Parameters:
NUM_NEURONS, 4, number of neuron weight memories driven (one wen bit each)
NUM_WEIGHT, 784, weights per neuron; read pointer wraps at this value
ADDR_WIDTH, 10, width of wadd/radd/cfg_count; must satisfy 2^ADDR_WIDTH >= NUM_WEIGHT
DATA_WIDTH, 16, weight word width
NEURON_W, 3, width of cfg_neuron; must hold NUM_NEURONS

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
cfg_valid  in  1  load command valid
cfg_ready  out  1  load command accepted when cfg_valid&cfg_ready
cfg_neuron  in  NEURON_W  target neuron index
cfg_count  in  ADDR_WIDTH  number of weights to load
w_valid  in  1  weight beat valid
w_ready  out  1  weight beat accepted when w_valid&w_ready
w_data  in  DATA_WIDTH  weight word
in_valid  in  1  one pulse per input sample for inference
err_clr  in  1  clears err
wen  out  NUM_NEURONS  one-hot write enable to weight memories
wadd  out  ADDR_WIDTH  write address
win  out  DATA_WIDTH  write data
ren  out  1  read enable, common to all neuron memories
radd  out  ADDR_WIDTH  read address, common
rd_last  out  1  high with ren when radd == NUM_WEIGHT-1
load_busy  out  1  high in LOAD
load_done  out  1  one-cycle pulse at load completion
err  out  1  sticky error flag

Behaviour:
- Reset (rst_n low at a clock edge): state IDLE. wen, wadd, win, ren, radd, rd_last, load_busy, load_done, err, cfg_ready and w_ready all 0. Write counter, read pointer and latched neuron/count all 0. Reset mid-load abandons the load with no further wen and no load_done.
- States: IDLE, LOAD, DONE.
- IDLE:
  - cfg_ready = 1 only when the read pointer is 0, i.e. no inference sample is partially read out.
  - On cfg accept, latch cfg_neuron and cfg_count, clear the write counter, and go to LOAD.
  - If cfg_count == 0, go directly to DONE; no writes occur.
- LOAD:
  - load_busy = 1, w_ready = 1, cfg_ready = 0.
  - Each accepted beat produces, on the next cycle, a one-cycle wen pulse with wen[latched neuron] = 1, wadd = write counter, win = w_data. The counter then increments. Latency is 1 cycle from beat to wen.
  - When the accepted-beat count reaches the latched count, deassert w_ready in the same cycle as the last accept and go to DONE.
  - cfg_count > NUM_WEIGHT: clamp to NUM_WEIGHT and set err.
  - Latched neuron >= NUM_NEURONS: beats are consumed, wen stays 0, err is set (unless the optional feature applies).
- DONE: load_done = 1 for one cycle (coincides with the last wen), then IDLE.
- Read sequencing:
  - In IDLE, each in_valid produces, on the next cycle, ren = 1 and radd = read pointer for one cycle.
  - The pointer increments and wraps from NUM_WEIGHT-1 to 0. rd_last is asserted on the wrap beat.
  - Back-to-back in_valid gives consecutive addresses every cycle.
- Arbitration:
  - in_valid in LOAD or DONE is dropped (no ren, pointer unchanged) and sets err.
  - in_valid and cfg_valid in the same IDLE cycle with pointer 0: the read wins; cfg_ready is 0 for that cycle.
- wadd and win hold their last values when wen = 0. radd holds its value when ren = 0.
- err: set by the conditions above; cleared by err_clr when no set condition occurs the same cycle (set wins).

Optional Feature:
Macro BROADCAST_LOAD_EN.
- Defined: latched neuron == NUM_NEURONS means broadcast. Every write drives all wen bits high with the same wadd/win, and err is not set.
- Undefined: that value is out of range and is handled as above (beats consumed, wen = 0, err set).

Test Plan:
- cfg neuron=2, count=3; beats 0x0011, 0x0022, 0x0033 back-to-back -> wen=4'b0100 for 3 cycles with wadd 0,1,2 and matching win; load_done pulses with the third wen; then IDLE with cfg_ready=1.
- NUM_WEIGHT=4; drive 5 in_valid pulses -> ren with radd 0,1,2,3,0, each 1 cycle after its in_valid; rd_last only at radd=3.
- Read pointer at 2 and cfg_valid held high -> cfg_ready=0 until 2 more in_valid wrap the pointer to 0, then the command is accepted.
- in_valid during LOAD -> no ren, err=1. err_clr the following cycle -> err=0. The load completes normally.
- cfg_count=0 -> load_done 2 cycles after accept, no wen; cfg_count=NUM_WEIGHT+5 -> exactly NUM_WEIGHT writes and err=1.
- cfg neuron=4 with NUM_NEURONS=4 and 2 beats -> with BROADCAST_LOAD_EN, wen=4'b1111 twice and err=0; without it, wen=0, both beats consumed, err=1.
- rst_n low after 1 of 3 beats -> all outputs 0 next cycle, no load_done, cfg_ready=1 after release.

Source files
------------

// File: rtl/weight_mem_ctrl.sv
// Load/inference sequencer for a layer's per-neuron weight memories.
// Define BROADCAST_LOAD_EN to make neuron index NUM_NEURONS a write-to-all target.
module weight_mem_ctrl #(
  parameter int NUM_NEURONS = 4,
  parameter int NUM_WEIGHT  = 784,
  parameter int ADDR_WIDTH  = 10,
  parameter int DATA_WIDTH  = 16,
  parameter int NEURON_W    = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [NEURON_W-1:0]    cfg_neuron,
  input  logic [ADDR_WIDTH-1:0]  cfg_count,
  input  logic                   w_valid,
  output logic                   w_ready,
  input  logic [DATA_WIDTH-1:0]  w_data,
  input  logic                   in_valid,
  input  logic                   err_clr,
  output logic [NUM_NEURONS-1:0] wen,
  output logic [ADDR_WIDTH-1:0]  wadd,
  output logic [DATA_WIDTH-1:0]  win,
  output logic                   ren,
  output logic [ADDR_WIDTH-1:0]  radd,
  output logic                   rd_last,
  output logic                   load_busy,
  output logic                   load_done,
  output logic                   err
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_e;

  // One extra bit so a clamped count of exactly 2^ADDR_WIDTH still fits.
  localparam int                    CW      = ADDR_WIDTH + 1;
  localparam logic [CW-1:0]         NW_C    = CW'(NUM_WEIGHT);
  localparam logic [ADDR_WIDTH-1:0] RD_LAST = ADDR_WIDTH'(NUM_WEIGHT - 1);
  localparam logic [NEURON_W-1:0]   NN_L    = NEURON_W'(NUM_NEURONS);

  state_e                  state_q, state_d;
  logic [NEURON_W-1:0]     neuron_q, neuron_d;
  logic [CW-1:0]           count_q, count_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   rptr_q, rptr_d;
  logic [NUM_NEURONS-1:0]  wen_q, wen_d;
  logic [ADDR_WIDTH-1:0]   wadd_q, wadd_d;
  logic [DATA_WIDTH-1:0]   win_q, win_d;
  logic                    ren_q, ren_d;
  logic [ADDR_WIDTH-1:0]   radd_q, radd_d;
  logic                    rd_last_q, rd_last_d;
  logic                    err_q, err_d;
  logic                    err_set;
  logic                    cfg_bad;
  logic [NUM_NEURONS-1:0]  tgt_mask;

  always_comb begin
`ifdef BROADCAST_LOAD_EN
    cfg_bad  = (cfg_neuron > NN_L);
    tgt_mask = (neuron_q == NN_L) ? '1 :
               (neuron_q < NN_L)  ? (NUM_NEURONS'(1) << neuron_q) : '0;
`else
    cfg_bad  = (cfg_neuron >= NN_L);
    tgt_mask = (neuron_q < NN_L) ? (NUM_NEURONS'(1) << neuron_q) : '0;
`endif
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves a latch.
    state_d   = state_q;
    neuron_d  = neuron_q;
    count_d   = count_q;
    cnt_d     = cnt_q;
    rptr_d    = rptr_q;
    wen_d     = '0;
    wadd_d    = wadd_q;
    win_d     = win_q;
    ren_d     = 1'b0;
    radd_d    = radd_q;
    rd_last_d = 1'b0;
    err_set   = 1'b0;
    cfg_ready = 1'b0;
    w_ready   = 1'b0;
    load_busy = 1'b0;
    load_done = 1'b0;

    case (state_q)
      S_IDLE: begin
        // A new load may only start between samples; a read in the same cycle wins.
        cfg_ready = rst_n && (rptr_q == '0) && !in_valid;
        if (in_valid) begin
          ren_d     = 1'b1;
          radd_d    = rptr_q;
          rd_last_d = (rptr_q == RD_LAST);
          rptr_d    = (rptr_q == RD_LAST) ? '0 : rptr_q + 1'b1;
        end else if (cfg_valid && cfg_ready) begin
          neuron_d = cfg_neuron;
          count_d  = ({1'b0, cfg_count} > NW_C) ? NW_C : {1'b0, cfg_count};
          cnt_d    = '0;
          state_d  = S_LOAD;
          err_set  = ({1'b0, cfg_count} > NW_C) || cfg_bad;
        end
      end
      S_LOAD: begin
        load_busy = 1'b1;
        w_ready   = (cnt_q != count_q);
        err_set   = in_valid;
        if (cnt_q == count_q) begin
          state_d = S_DONE;
        end else if (w_valid) begin
          wen_d  = tgt_mask;
          wadd_d = cnt_q[ADDR_WIDTH-1:0];
          win_d  = w_data;
          cnt_d  = cnt_q + CW'(1);
          if (cnt_q + CW'(1) == count_q) state_d = S_DONE;
        end
      end
      S_DONE: begin
        load_done = 1'b1;
        err_set   = in_valid;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    err_d = err_set | (err_q & ~err_clr);
  end

  // NOTE: state registers use non-blocking assignments only; reset is sampled on the clock edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      neuron_q  <= '0;
      count_q   <= '0;
      cnt_q     <= '0;
      rptr_q    <= '0;
      wen_q     <= '0;
      wadd_q    <= '0;
      win_q     <= '0;
      ren_q     <= 1'b0;
      radd_q    <= '0;
      rd_last_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      neuron_q  <= neuron_d;
      count_q   <= count_d;
      cnt_q     <= cnt_d;
      rptr_q    <= rptr_d;
      wen_q     <= wen_d;
      wadd_q    <= wadd_d;
      win_q     <= win_d;
      ren_q     <= ren_d;
      radd_q    <= radd_d;
      rd_last_q <= rd_last_d;
      err_q     <= err_d;
    end
  end

  assign wen     = wen_q;
  assign wadd    = wadd_q;
  assign win     = win_q;
  assign ren     = ren_q;
  assign radd    = radd_q;
  assign rd_last = rd_last_q;
  assign err     = err_q;

endmodule

// File: tb/tb_weight_mem_ctrl.sv
// Self-checking bench for weight_mem_ctrl: per-cycle reference model plus
// directed scenarios with hand-computed expectations.
module tb_weight_mem_ctrl;

  localparam int NN = 4;
  localparam int NW = 4;
  localparam int AW = 10;
  localparam int DW = 16;
  localparam int NBW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [NBW-1:0] cfg_neuron = '0;
  logic [AW-1:0] cfg_count = '0;
  logic          w_valid = 1'b0;
  logic          w_ready;
  logic [DW-1:0] w_data = '0;
  logic          in_valid = 1'b0;
  logic          err_clr = 1'b0;
  logic [NN-1:0] wen;
  logic [AW-1:0] wadd;
  logic [DW-1:0] win;
  logic          ren;
  logic [AW-1:0] radd;
  logic          rd_last;
  logic          load_busy;
  logic          load_done;
  logic          err;

  weight_mem_ctrl #(
    .NUM_NEURONS(NN), .NUM_WEIGHT(NW), .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW), .NEURON_W(NBW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_neuron(cfg_neuron), .cfg_count(cfg_count),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .in_valid(in_valid), .err_clr(err_clr),
    .wen(wen), .wadd(wadd), .win(win),
    .ren(ren), .radd(radd), .rd_last(rd_last),
    .load_busy(load_busy), .load_done(load_done), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NN-1:0] mask_of(input int t);
`ifdef BROADCAST_LOAD_EN
    if (t == NN) return '1;
`endif
    if (t < NN) return NN'(1 << t);
    return '0;
  endfunction

  function automatic bit bad_target(input int t);
`ifdef BROADCAST_LOAD_EN
    return t > NN;
`else
    return t >= NN;
`endif
  endfunction

  // Reference model: a load is "remaining beats to a target", reads are a modulo counter.
  bit            m_load = 0, m_fin = 0;
  int            m_left = 0, m_idx = 0, m_ptr = 0, m_tgt = 0;
  logic [NN-1:0] e_wen = '0;
  logic [AW-1:0] e_wadd = '0, e_radd = '0;
  logic [DW-1:0] e_win = '0;
  logic          e_ren = 0, e_last = 0, e_err = 0;

  always @(posedge clk) begin
    bit set;
    if (!rst_n) begin
      m_load = 0; m_fin = 0; m_left = 0; m_idx = 0; m_ptr = 0; m_tgt = 0;
      e_wen = '0; e_wadd = '0; e_win = '0; e_ren = 0; e_radd = '0; e_last = 0; e_err = 0;
    end else begin
      set = 0; e_wen = '0; e_ren = 0; e_last = 0;
      if (m_fin) begin
        set = in_valid;
        m_fin = 0;
      end else if (m_load) begin
        set = in_valid;
        if (m_left == 0) begin
          m_load = 0; m_fin = 1;
        end else if (w_valid) begin
          e_wen = mask_of(m_tgt); e_wadd = AW'(m_idx); e_win = w_data;
          m_idx++; m_left--;
          if (m_left == 0) begin m_load = 0; m_fin = 1; end
        end
      end else if (in_valid) begin
        e_ren = 1; e_radd = AW'(m_ptr); e_last = (m_ptr == NW - 1);
        m_ptr = (m_ptr + 1) % NW;
      end else if (cfg_valid && m_ptr == 0) begin
        m_tgt = int'(cfg_neuron);
        m_left = (int'(cfg_count) > NW) ? NW : int'(cfg_count);
        m_idx = 0; m_load = 1;
        set = (int'(cfg_count) > NW) || bad_target(m_tgt);
      end
      if (set) e_err = 1;
      else if (err_clr) e_err = 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("wen", wen, e_wen);
      check("wadd", wadd, e_wadd);
      check("win", win, e_win);
      check("ren", ren, e_ren);
      check("radd", radd, e_radd);
      check("rd_last", rd_last, e_last);
      check("err", err, e_err);
      check("load_busy", load_busy, m_load);
      check("load_done", load_done, m_fin);
      check("w_ready", w_ready, m_load && m_left != 0);
      check("cfg_ready", cfg_ready, rst_n && !m_load && !m_fin && m_ptr == 0 && !in_valid);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_cfg(input int n, input int c);
    cfg_valid = 1; cfg_neuron = NBW'(n); cfg_count = AW'(c);
    tick();
    cfg_valid = 0;
  endtask

  initial begin
    int nw;
    tick(); tick();
    chk_en = 1;
    check("rst_wen", wen, 0);
    check("rst_ren", ren, 0);
    check("rst_err", err, 0);
    check("rst_cfg_ready", cfg_ready, 0);
    rst_n = 1;
    #1 check("idle_cfg_ready", cfg_ready, 1);

    // Load neuron 2 with three back-to-back beats.
    start_cfg(2, 3);
    w_valid = 1; w_data = 16'h0011; tick();
    check("ld1_wen", wen, 4'b0100); check("ld1_wadd", wadd, 0); check("ld1_win", win, 16'h0011);
    w_data = 16'h0022; tick();
    check("ld2_wadd", wadd, 1); check("ld2_win", win, 16'h0022);
    w_data = 16'h0033; tick();
    check("ld3_wen", wen, 4'b0100); check("ld3_wadd", wadd, 2); check("ld3_done", load_done, 1);
    w_valid = 0; tick();
    check("ld_after_done", load_done, 0); check("ld_after_rdy", cfg_ready, 1);

    // Five back-to-back reads wrap the pointer once.
    in_valid = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("rd_ren", ren, 1);
      check("rd_radd", radd, i % NW);
      check("rd_last_lit", rd_last, (i == 3));
    end
    in_valid = 0; tick();
    check("rd_idle_ren", ren, 0); check("rd_hold_radd", radd, 0);

    // Pointer to 2, then a pending command waits for the wrap.
    in_valid = 1; tick(); in_valid = 0;
    cfg_valid = 1; cfg_neuron = 1; cfg_count = 2;
    #1 check("blk_cfg_ready", cfg_ready, 0);
    tick();
    in_valid = 1; tick(); tick(); in_valid = 0;
    #1 check("wrap_cfg_ready", cfg_ready, 1);
    tick(); cfg_valid = 0;
    check("acc_busy", load_busy, 1);

    // Read during load is dropped and flags err; err_clr clears it.
    in_valid = 1; tick(); in_valid = 0; err_clr = 1;
    check("drop_ren", ren, 0); check("drop_err", err, 1);
    tick(); err_clr = 0;
    check("clr_err", err, 0);
    w_valid = 1; w_data = 16'h00A1; tick();
    check("ld_n1_wen", wen, 4'b0010);
    w_data = 16'h00A2; tick();
    check("ld_n1_wadd", wadd, 1); check("ld_n1_done", load_done, 1);
    w_valid = 0; tick();

    // Zero-length load.
    start_cfg(0, 0);
    check("z_done0", load_done, 0);
    tick();
    check("z_done1", load_done, 1); check("z_wen", wen, 0);
    tick();

    // Oversized count is clamped to NUM_WEIGHT writes.
    start_cfg(3, NW + 5);
    check("big_err", err, 1);
    nw = 0; w_valid = 1;
    for (int i = 0; i < 8; i++) begin
      w_data = DW'(16'h0100 + i); tick();
      if (wen != 0) nw++;
    end
    w_valid = 0;
    check("big_writes", nw, NW);
    err_clr = 1; tick(); err_clr = 0;

    // Neuron index equal to NUM_NEURONS.
    start_cfg(NN, 2);
    w_valid = 1; w_data = 16'h0BEE; tick();
`ifdef BROADCAST_LOAD_EN
    check("bc_wen1", wen, 4'b1111);
`else
    check("oor_wen1", wen, 4'b0000);
`endif
    w_data = 16'h0BEF; tick(); w_valid = 0;
`ifdef BROADCAST_LOAD_EN
    check("bc_wen2", wen, 4'b1111); check("bc_err", err, 0);
`else
    check("oor_wen2", wen, 4'b0000); check("oor_err", err, 1);
`endif
    check("oor_done", load_done, 1);
    tick(); err_clr = 1; tick(); err_clr = 0;

    // Reset in the middle of a load.
    start_cfg(1, 3);
    w_valid = 1; w_data = 16'h0C01; tick();
    w_valid = 0; rst_n = 0; tick();
    check("mr_wen", wen, 0); check("mr_busy", load_busy, 0);
    check("mr_done", load_done, 0); check("mr_cfg_ready", cfg_ready, 0);
    check("mr_w_ready", w_ready, 0);
    rst_n = 1;
    #1 check("mr_rel_cfg_ready", cfg_ready, 1);
    tick();
    check("mr_no_done", load_done, 0);
    tick(); tick();

    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
